// File: rtl/seq_normaliser16bit_pkg.sv
// Shared constants for the sequential 16-bit left-normaliser.
// Also holds the stage-to-shift-amount mapping used by its FSM.
package seq_normaliser16bit_pkg;

  localparam int WIDTH = 16;
  localparam int MAGW  = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_S8   = 3'd1;
  localparam logic [2:0] ST_S4   = 3'd2;
  localparam logic [2:0] ST_S2   = 3'd3;
  localparam logic [2:0] ST_S1   = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  // The shift amount is one-hot, so it doubles as the mag bit that the stage sets.
  function automatic logic [MAGW-1:0] stage_amt(input logic [2:0] st);
    case (st)
      ST_S8:   stage_amt = 4'd8;
      ST_S4:   stage_amt = 4'd4;
      ST_S2:   stage_amt = 4'd2;
      ST_S1:   stage_amt = 4'd1;
      default: stage_amt = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/seq_normaliser16bit_norm_stage.sv
// One binary-search stage: if the top i_amt bits of i_r are all zero,
// shift left by i_amt with zero fill and flag it. An amount of 0 is a pass-through.
module seq_normaliser16bit_norm_stage
  import seq_normaliser16bit_pkg::*;
(
  input  logic [WIDTH-1:0] i_r,
  input  logic [MAGW-1:0]  i_amt,
  output logic [WIDTH-1:0] o_r,
  output logic             o_shift
);

  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_shifted;

  assign w_mask    = ~({WIDTH{1'b1}} >> i_amt);
  assign w_shifted = i_r << i_amt;
  assign o_shift   = (i_amt != '0) && ((i_r & w_mask) == '0);

  // Each output bit is a 1-bit 2:1 mux, the same structure as a barrel-shifter stage.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    assign o_r[i] = o_shift ? w_shifted[i] : i_r[i];
  end

endmodule

// File: rtl/seq_normaliser16bit.sv
// Sequential left-normaliser: one search stage (8, 4, 2, 1) per clock.
// It returns the normalised word Q, the shift magnitude mag and a zero flag.
module seq_normaliser16bit
  import seq_normaliser16bit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [MAGW-1:0]  mag,
  output logic             zero
);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [WIDTH-1:0] r_r;
  logic [MAGW-1:0]  r_mag;
  logic             r_zero;

  logic [MAGW-1:0]  w_amt;
  logic [WIDTH-1:0] w_r_nxt;
  logic             w_shift_bit;
  logic             w_load;

  assign busy   = (r_state == ST_S8) || (r_state == ST_S4) ||
                  (r_state == ST_S2) || (r_state == ST_S1);
  assign done   = (r_state == ST_DONE);
  assign w_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_amt  = stage_amt(r_state);

  seq_normaliser16bit_norm_stage u_stage (
    .i_r     (r_r),
    .i_amt   (w_amt),
    .o_r     (w_r_nxt),
    .o_shift (w_shift_bit)
  );

  always_comb begin
    // NOTE: default assignment first so every path drives w_state_nxt; no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_S8;
      ST_S8:   w_state_nxt = ST_S4;
      ST_S4:   w_state_nxt = ST_S2;
      ST_S2:   w_state_nxt = ST_S1;
      ST_S1:   w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = start ? ST_S8 : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_r     <= '0;
      r_mag   <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_r    <= A;
        r_mag  <= '0;
        r_zero <= (A == '0);
      end else if (busy) begin
        r_r <= w_r_nxt;
        if (w_shift_bit) r_mag <= r_mag | w_amt;
      end
    end
  end

  assign Q    = r_r;
  assign mag  = r_mag;
  assign zero = r_zero;

endmodule
